// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants and writeback controller state type.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_LB     = 3'b000;
    localparam logic [2:0] F3_LH     = 3'b001;
    localparam logic [2:0] F3_LW     = 3'b010;
    localparam logic [2:0] F3_LBU    = 3'b100;
    localparam logic [2:0] F3_LHU    = 3'b101;

    typedef enum logic {
        IDLE,
        WAIT_LOAD
    } wb_state_t;

endpackage

// File: rtl/wb_lane_decode.sv
// Per-lane writeback decode: register-write intent, data source select and
// load byte/halfword extraction with sign/zero extension.
import riscv_pkg::*;

module wb_lane_decode #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              lane_valid,
    input  logic [XLEN-1:0]   instr,
    input  logic [XLEN-1:0]   alu_result,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   rdata,
    output logic              wr,
    output logic              is_load,
    output logic [REG_AW-1:0] rd,
    output logic [XLEN-1:0]   data
);

    localparam int IW = $clog2(XLEN);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [1:0]      off;
    logic [IW-1:0]   byte_lsb;
    logic [IW-1:0]   half_lsb;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic [XLEN-1:0] load_data;
    logic            wr_op;
    logic            unused_instr_hi;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign rd       = instr[7 +: REG_AW];
    assign off      = alu_result[1:0];
    assign byte_lsb = IW'({off, 3'b000});
    assign half_lsb = IW'({off[1], 4'b0000});
    assign byte_v   = rdata[byte_lsb +: 8];
    assign half_v   = rdata[half_lsb +: 16];
    assign unused_instr_hi = ^instr[XLEN-1:15];

    // Load data extraction from the aligned DRAM word
    always_comb begin
        load_data = rdata;
        case (funct3)
            F3_LB:   load_data = {{(XLEN-8){byte_v[7]}}, byte_v};
            F3_LBU:  load_data = {{(XLEN-8){1'b0}}, byte_v};
            F3_LH:   load_data = {{(XLEN-16){half_v[15]}}, half_v};
            F3_LHU:  load_data = {{(XLEN-16){1'b0}}, half_v};
            default: load_data = rdata;
        endcase
    end

    // Opcode decode: write intent and writeback data source
    always_comb begin
        wr_op   = 1'b0;
        is_load = 1'b0;
        data    = alu_result;
        case (opcode)
            OP_R, OP_IMM, OP_LUI, OP_AUIPC: wr_op = 1'b1;
            OP_JAL, OP_JALR: begin
                wr_op = 1'b1;
                data  = pc + XLEN'(4);
            end
            OP_LOAD: begin
                wr_op   = 1'b1;
                is_load = lane_valid;
                data    = load_data;
            end
            default: wr_op = 1'b0;
        endcase
        wr = wr_op && lane_valid && (rd != '0);
    end

endmodule

// File: rtl/wb_commit_ctrl.sv
// Multi-lane writeback/commit controller: accepts issue bundles, waits on a
// single outstanding DRAM load, resolves in-bundle WAW and drives registered
// regfile write ports.
import riscv_pkg::*;

module wb_commit_ctrl #(
    parameter int NUM_LANES = 2,
    parameter int XLEN      = 32,
    parameter int REG_AW    = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_LANES-1:0]        in_lane_valid,
    input  logic [NUM_LANES*XLEN-1:0]   in_instr,
    input  logic [NUM_LANES*XLEN-1:0]   in_alu_result,
    input  logic [NUM_LANES*XLEN-1:0]   in_pc,
    input  logic                        dram_rvalid,
    input  logic [XLEN-1:0]             dram_rdata,
    output logic [NUM_LANES-1:0]        rf_we,
    output logic [NUM_LANES*REG_AW-1:0] rf_waddr,
    output logic [NUM_LANES*XLEN-1:0]   rf_wdata,
    output logic                        err_multi_load,
    output logic                        err_stray_rsp
);

    wb_state_t state;

    logic [NUM_LANES-1:0]      cap_lane_valid;
    logic [NUM_LANES*XLEN-1:0] cap_instr;
    logic [NUM_LANES*XLEN-1:0] cap_alu;
    logic [NUM_LANES*XLEN-1:0] cap_pc;

    logic [NUM_LANES-1:0]      src_lane_valid;
    logic [NUM_LANES*XLEN-1:0] src_instr;
    logic [NUM_LANES*XLEN-1:0] src_alu;
    logic [NUM_LANES*XLEN-1:0] src_pc;

    logic [NUM_LANES-1:0]      lane_wr;
    logic [NUM_LANES-1:0]      lane_load;
    logic [REG_AW-1:0]         lane_rd   [NUM_LANES];
    logic [XLEN-1:0]           lane_data [NUM_LANES];

    logic [NUM_LANES-1:0]      keep;
    logic [NUM_LANES-1:0]      commit_we;
    logic                      has_load;
    logic                      multi_load;
    logic                      commit_now;

    // While waiting on DRAM the captured bundle is decoded instead of the inputs
    assign src_lane_valid = (state == IDLE) ? in_lane_valid : cap_lane_valid;
    assign src_instr      = (state == IDLE) ? in_instr      : cap_instr;
    assign src_alu        = (state == IDLE) ? in_alu_result : cap_alu;
    assign src_pc         = (state == IDLE) ? in_pc         : cap_pc;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        wb_lane_decode #(
            .XLEN   (XLEN),
            .REG_AW (REG_AW)
        ) u_dec (
            .lane_valid (src_lane_valid[g]),
            .instr      (src_instr[g*XLEN +: XLEN]),
            .alu_result (src_alu[g*XLEN +: XLEN]),
            .pc         (src_pc[g*XLEN +: XLEN]),
            .rdata      (dram_rdata),
            .wr         (lane_wr[g]),
            .is_load    (lane_load[g]),
            .rd         (lane_rd[g]),
            .data       (lane_data[g])
        );
    end

    // Oldest load owns the memory response; younger writers to the same rd win
    always_comb begin
        keep       = '0;
        commit_we  = '0;
        has_load   = 1'b0;
        multi_load = 1'b0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            keep[i] = lane_wr[i];
            if (lane_load[i]) begin
                if (has_load) begin
                    keep[i]    = 1'b0;
                    multi_load = 1'b1;
                end
                has_load = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            commit_we[i] = keep[i];
            for (int unsigned j = i + 1; j < NUM_LANES; j++) begin
                if (keep[j] && (lane_rd[j] == lane_rd[i])) begin
                    commit_we[i] = 1'b0;
                end
            end
        end
    end

    // A commit happens for a non-stalling accept or for the awaited response
    always_comb begin
        commit_now = 1'b0;
        if (state == IDLE) begin
            commit_now = in_valid && !(has_load && !dram_rvalid);
        end else begin
            commit_now = dram_rvalid;
        end
    end

    // FSM, bundle capture, sticky error flags and registered write ports
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            in_ready       <= 1'b1;
            rf_we          <= '0;
            rf_waddr       <= '0;
            rf_wdata       <= '0;
            err_multi_load <= 1'b0;
            err_stray_rsp  <= 1'b0;
            cap_lane_valid <= '0;
            cap_instr      <= '0;
            cap_alu        <= '0;
            cap_pc         <= '0;
        end else begin
            rf_we <= '0;
            if (commit_now) begin
                rf_we <= commit_we;
                for (int unsigned i = 0; i < NUM_LANES; i++) begin
                    if (commit_we[i]) begin
                        rf_waddr[i*REG_AW +: REG_AW] <= lane_rd[i];
                        rf_wdata[i*XLEN +: XLEN]     <= lane_data[i];
                    end
                end
            end
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (multi_load) begin
                            err_multi_load <= 1'b1;
                        end
                        if (has_load && !dram_rvalid) begin
                            cap_lane_valid <= in_lane_valid;
                            cap_instr      <= in_instr;
                            cap_alu        <= in_alu_result;
                            cap_pc         <= in_pc;
                            state          <= WAIT_LOAD;
                            in_ready       <= 1'b0;
                        end
                    end
                    if (dram_rvalid && !(in_valid && has_load)) begin
                        err_stray_rsp <= 1'b1;
                    end
                end
                WAIT_LOAD: begin
                    if (dram_rvalid) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/wb_commit_ctrl.md
Name: wb_commit_ctrl

Overview:
- Parametrised multi-lane writeback/commit controller for the dual-issue RISC-V pipeline; successor to the single-lane combinational regwrite/write-data decoder.
- Accepts one issue bundle of NUM_LANES instructions per handshake, decodes per-lane register-write intent, and selects ALU / load / link data.
- Performs load byte/halfword extraction and sign extension, and waits on a multi-cycle DRAM read response.
- Resolves same-rd conflicts inside a bundle and drives registered regfile write ports.

Parameters:
- NUM_LANES, 2, issue width (lanes per bundle, lane 0 oldest); legal 1..4
- XLEN, 32, data/instruction width
- REG_AW, 5, register address width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  bundle present
- in_ready  out  1  controller can accept a bundle this cycle
- in_lane_valid  in  NUM_LANES  per-lane instruction valid (bubble when 0)
- in_instr  in  NUM_LANES*XLEN  lane i at [i*XLEN +: XLEN]
- in_alu_result  in  NUM_LANES*XLEN  ALU result; for loads, the byte address
- in_pc  in  NUM_LANES*XLEN  lane PC
- dram_rvalid  in  1  load response valid (single memory port)
- dram_rdata  in  XLEN  aligned word containing the load target
- rf_we  out  NUM_LANES  registered per-lane write enable
- rf_waddr  out  NUM_LANES*REG_AW  registered rd
- rf_wdata  out  NUM_LANES*XLEN  registered write data
- err_multi_load  out  1  sticky: bundle with >1 valid load accepted
- err_stray_rsp  out  1  sticky: dram_rvalid while no load pending

Behaviour:
- Reset: state=IDLE; in_ready=1 next cycle; rf_we=0, rf_waddr=0, rf_wdata=0, both err flags=0; any captured bundle dropped, including mid-WAIT_LOAD.
- Accept when in_valid && in_ready. in_ready = (state==IDLE).
- Per-lane decode (opcode instr[6:0]):
  - R (0110011), I-ALU (0010011), LUI, AUIPC: we=1, data=alu_result.
  - JAL, JALR: we=1, data=pc+4 (mod 2^XLEN).
  - LOAD (0000011): we=1, data from DRAM.
  - STORE, BRANCH, all others: we=0.
- Load extract: off=alu_result[1:0].
  - LB/LBU: byte at off*8, sign/zero extend.
  - LH/LHU: half at off[1]*16, sign/zero extend.
  - LW: full word.
  - Other funct3: treated as LW.
- rd==0 forces we=0 for that lane; lane_valid=0 forces we=0.
- WAW: if lanes i<j both write the same nonzero rd, lane i we=0; the youngest writer wins.
- FSM:
  - IDLE, no valid load in bundle: register outputs at the next edge (latency 1), stay IDLE.
  - IDLE, load present and dram_rvalid same cycle: same as above, using dram_rdata.
  - IDLE, load present without dram_rvalid: capture bundle, go WAIT_LOAD; rf_we=0 while waiting.
  - WAIT_LOAD: in_ready=0. On dram_rvalid, register all lanes of the captured bundle next edge and return to IDLE. A bundle may be accepted in the following cycle.
- rf_we is a one-cycle pulse per commit; rf_we=0 on every cycle with no commit. rf_waddr/rf_wdata hold their last value when rf_we=0.
- >1 load in bundle: set err_multi_load. The lowest-index load receives dram_rdata; other loads' we=0.
- dram_rvalid in IDLE with no accepted load bundle: ignore data, set err_stray_rsp.
- in_valid with all lane_valid=0: accepted, commits nothing.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR);
  - load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU);
  - state enum {IDLE, WAIT_LOAD}.
- One sub-module, wb_lane_decode: combinational per-lane regwrite/select/extract, instantiated NUM_LANES times via generate.
- FSM, capture registers, WAW resolution and output registers live in the top module.

Test Plan:
- Lane0 ADD x5 alu=0x11, lane1 JAL x1 pc=0x100, in_valid=1 -> next cycle rf_we=2'b11, waddr={1,5}, wdata={0x104,0x11}.
- Lane0 LB x6 addr=0x1003, dram_rvalid delayed 3 cycles with rdata=0x80FF_FF00 -> in_ready=0 and rf_we=0 for 3 cycles; cycle after rvalid rf_we[0]=1, wdata=0xFFFF_FF80; FSM IDLE.
- LHU x7 addr=0x2002, rvalid same cycle, rdata=0xBEEF_1234 -> next cycle wdata=0x0000_BEEF; latency 1.
- Both lanes ADDI x9 (alu 0x1, 0x2) -> rf_we=2'b10, lane1 wdata=0x2; ADD x0 -> we=0; SW/BEQ lanes -> we=0.
- Reset asserted in WAIT_LOAD, then rvalid -> no write; err_stray_rsp=1; after a later rst, all outputs 0.
- Bundle with two LW -> err_multi_load=1, only lane0 written with rdata.
